// File: rtl/board_number_sequencer.sv
// -----------------------------------------------------------------------------
// board_number_sequencer
//
// Walks the 16 cells of the 4x4 sliding-puzzle board in raster order. For each
// non-blank tile it clears and then enables the selected number-glyph drawer
// for one fixed drawing window. The drawer's pixel coordinates are registered
// onto the VGA adapter write port. A one-cycle done pulse closes the frame.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous, active-high
//   start         single-cycle redraw request (ignored unless idle)
//   tile_addr     board store read address, row*4+col
//   tile_value    board store read data (combinational, same cycle)
//   glyph_sel     selects which glyph drawer's outputs come back
//   glyph_x/y     cell origin for the drawer
//   glyph_enable  drawer enable
//   glyph_resetn  drawer reset, active-low
//   pix_x/y       selected drawer pixel coordinates
//   vga_x/y       VGA plot coordinates
//   vga_colour    VGA plot colour (constant)
//   vga_plot      VGA write strobe
//   busy          frame in progress
//   done          one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module board_number_sequencer #(
   parameter logic [7:0] BOARD_X0    = 8'd20,
   parameter logic [6:0] BOARD_Y0    = 7'd0,
   parameter int         CELL        = 30,
   parameter int         DRAW_CYCLES = 141,
   parameter logic [2:0] FG_COLOUR   = 3'b111
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic [3:0] tile_addr,
   input  logic [3:0] tile_value,
   output logic [3:0] glyph_sel,
   output logic [7:0] glyph_x,
   output logic [6:0] glyph_y,
   output logic       glyph_enable,
   output logic       glyph_resetn,
   input  logic [7:0] pix_x,
   input  logic [6:0] pix_y,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CLEAR,
      S_DRAW,
      S_NEXT,
      S_DONE
   } state_t;

   localparam logic [7:0] CELL_X   = 8'(CELL);
   localparam logic [6:0] CELL_Y   = 7'(CELL);
   localparam logic [7:0] LAST_CNT = 8'(DRAW_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] idx_q;
   logic [7:0] draw_cnt_q;
   logic [3:0] glyph_sel_q;
   logic [7:0] glyph_x_q;
   logic [6:0] glyph_y_q;
   logic [7:0] vga_x_q;
   logic [6:0] vga_y_q;
   logic       vga_plot_q;

   logic [7:0] origin_x;
   logic [6:0] origin_y;

   // Column selects x, row selects y.
   assign origin_x = BOARD_X0 + ({6'd0, idx_q[1:0]} * CELL_X);
   assign origin_y = BOARD_Y0 + ({5'd0, idx_q[3:2]} * CELL_Y);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   // NOTE: state_d gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_FETCH;
         S_FETCH: state_d = (tile_value == 4'd0) ? S_NEXT : S_CLEAR;
         S_CLEAR: state_d = S_DRAW;
         S_DRAW:  if (draw_cnt_q == LAST_CNT) state_d = S_NEXT;
         S_NEXT:  state_d = (idx_q == 4'd15) ? S_DONE : S_FETCH;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State-decoded outputs
   // ---------------------------------------------------------------------------
   // Drawer reset is held only in IDLE and CLEAR, so each drawing window is
   // preceded by exactly one reset cycle and a mid-frame reset drops it at once.
   always_comb begin
      glyph_resetn = 1'b1;
      glyph_enable = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            glyph_resetn = 1'b0;
            busy         = 1'b0;
         end
         S_CLEAR: glyph_resetn = 1'b0;
         S_DRAW:  glyph_enable = 1'b1;
         S_DONE:  done         = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Sequencing datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q       <= 4'd0;
         draw_cnt_q  <= 8'd0;
         glyph_sel_q <= 4'd0;
         glyph_x_q   <= 8'd0;
         glyph_y_q   <= 7'd0;
      end else begin
         unique case (state_q)
            S_IDLE: if (start) idx_q <= 4'd0;
            S_FETCH: begin
               glyph_sel_q <= tile_value;
               glyph_x_q   <= origin_x;
               glyph_y_q   <= origin_y;
            end
            S_CLEAR: draw_cnt_q <= 8'd0;
            S_DRAW:  draw_cnt_q <= draw_cnt_q + 8'd1;
            S_NEXT:  if (idx_q != 4'd15) idx_q <= idx_q + 4'd1;
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Plot path: one-cycle registered copy of the drawer output, so the plot
   // strobe trails DRAW by one cycle and the last plot lands in NEXT.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_x_q    <= 8'd0;
         vga_y_q    <= 7'd0;
         vga_plot_q <= 1'b0;
      end else begin
         vga_x_q    <= pix_x;
         vga_y_q    <= pix_y;
         vga_plot_q <= (state_q == S_DRAW);
      end
   end

   assign tile_addr  = idx_q;
   assign glyph_sel  = glyph_sel_q;
   assign glyph_x    = glyph_x_q;
   assign glyph_y    = glyph_y_q;
   assign vga_x      = vga_x_q;
   assign vga_y      = vga_y_q;
   assign vga_plot   = vga_plot_q;
   assign vga_colour = FG_COLOUR;

endmodule

// File: tb/tb_board_number_sequencer.sv
// -----------------------------------------------------------------------------
// tb_board_number_sequencer
//
// Directed bench for board_number_sequencer. A small board-store array and a
// glyph drawer model (counter cleared by glyph_resetn, advanced by
// glyph_enable, offset added to the cell origin) surround the DUT.
// -----------------------------------------------------------------------------
module tb_board_number_sequencer;

   localparam int DRAW = 141;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] tile_addr, tile_value, glyph_sel;
   logic [7:0] glyph_x, pix_x, vga_x;
   logic [6:0] glyph_y, pix_y, vga_y;
   logic       glyph_enable, glyph_resetn, vga_plot, busy, done;
   logic [2:0] vga_colour;

   logic [3:0] board [16];
   logic [7:0] dcnt;

   int checks = 0;
   int errors = 0;

   // Frame statistics gathered by run_frame
   int         done_cyc, plots, windows, bad_windows, en_total;
   logic       busy1, done_after, busy_after;
   logic [3:0] sel_log [16];
   logic [7:0] gx_log [16];
   logic [6:0] gy_log [16];
   logic [7:0] fvx_log [16];
   logic [6:0] fvy_log [16];

   board_number_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .tile_addr    (tile_addr),
      .tile_value   (tile_value),
      .glyph_sel    (glyph_sel),
      .glyph_x      (glyph_x),
      .glyph_y      (glyph_y),
      .glyph_enable (glyph_enable),
      .glyph_resetn (glyph_resetn),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .vga_x        (vga_x),
      .vga_y        (vga_y),
      .vga_colour   (vga_colour),
      .vga_plot     (vga_plot),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   assign tile_value = board[tile_addr];

   // Drawer model: offset starts at 0 on the first enabled cycle.
   always @(posedge clk) begin
      if (!glyph_resetn)     dcnt <= 8'd0;
      else if (glyph_enable) dcnt <= dcnt + 8'd1;
   end
   assign pix_x = glyph_x + {4'd0, dcnt[3:0]};
   assign pix_y = glyph_y + {3'd0, dcnt[7:4]};

   task automatic load_counting();
      for (int i = 0; i < 16; i++) board[i] = (i == 15) ? 4'd0 : 4'(i + 1);
   endtask

   task automatic load_blank();
      for (int i = 0; i < 16; i++) board[i] = 4'd0;
   endtask

   // Pulse start (edge E) and watch the frame until done or a cycle budget.
   // Cycle n is sampled on the falling edge inside cycle E+n.
   task automatic run_frame(input int restart_at);
      int   low_run, run, w_plot;
      logic prev_en, prev_plot;
      done_cyc = -1; plots = 0; windows = 0; bad_windows = 0; en_total = 0;
      low_run = 0; run = 0; w_plot = 0; prev_en = 1'b0; prev_plot = 1'b0;
      busy1 = 1'b0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int n = 1; n <= 5000; n++) begin
         @(negedge clk);
         if (n == restart_at)     start = 1'b1;
         if (n == restart_at + 1) start = 1'b0;
         if (n == 1) busy1 = busy;
         if (vga_plot) begin
            plots++;
            if (!prev_plot && w_plot < 16) begin
               fvx_log[w_plot] = vga_x;
               fvy_log[w_plot] = vga_y;
               w_plot++;
            end
         end
         if (glyph_enable) begin
            en_total++;
            if (!prev_en) begin
               if (low_run != 1) bad_windows++;
               if (windows < 16) begin
                  sel_log[windows] = glyph_sel;
                  gx_log[windows]  = glyph_x;
                  gy_log[windows]  = glyph_y;
               end
               windows++;
            end
            run++;
            low_run = 0;
         end else begin
            if (prev_en && run != DRAW) bad_windows++;
            run = 0;
            if (!glyph_resetn) low_run++;
            else               low_run = 0;
         end
         prev_en   = glyph_enable;
         prev_plot = vga_plot;
         if (done) begin
            done_cyc = n;
            break;
         end
      end
      start = 1'b0;
      @(negedge clk);
      done_after = done;
      busy_after = busy;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; load_blank();
      repeat (3) @(negedge clk);
      checks++; if (glyph_resetn !== 1'b0 || glyph_enable !== 1'b0) begin
         errors++; $display("FAIL reset_drawer got resetn=%b en=%b want 0 0", glyph_resetn, glyph_enable);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({busy, done, vga_plot} !== 3'b000) begin
         errors++; $display("FAIL idle_flags got busy/done/plot=%b want 000", {busy, done, vga_plot});
      end
      checks++; if ({tile_addr, glyph_sel, glyph_x, glyph_y} !== 23'd0) begin
         errors++; $display("FAIL idle_regs got addr=%0d sel=%0d x=%0d y=%0d want 0", tile_addr, glyph_sel, glyph_x, glyph_y);
      end
      checks++; if ({vga_x, vga_y} !== 15'd0 || vga_colour !== 3'b111) begin
         errors++; $display("FAIL idle_vga got x=%0d y=%0d col=%b want 0 0 111", vga_x, vga_y, vga_colour);
      end
      checks++; if (glyph_resetn !== 1'b0) begin
         errors++; $display("FAIL idle_resetn got %b want 0", glyph_resetn);
      end
   endtask

   task automatic test_full_board(input int restart_at, input string tag);
      load_counting();
      run_frame(restart_at);
      checks++; if (busy1 !== 1'b1) begin
         errors++; $display("FAIL %s busy_rise got %b want 1", tag, busy1);
      end
      checks++; if (done_cyc != 2163) begin
         errors++; $display("FAIL %s done_cycle got %0d want 2163", tag, done_cyc);
      end
      checks++; if (plots != 2115) begin
         errors++; $display("FAIL %s plot_total got %0d want 2115", tag, plots);
      end
      checks++; if (windows != 15 || en_total != 2115) begin
         errors++; $display("FAIL %s windows got %0d/%0d want 15/2115", tag, windows, en_total);
      end
      checks++; if (bad_windows != 0) begin
         errors++; $display("FAIL %s handshake got %0d bad want 0", tag, bad_windows);
      end
      for (int k = 0; k < 15; k++) begin
         checks++; if (sel_log[k] !== 4'(k + 1)) begin
            errors++; $display("FAIL %s glyph_sel[%0d] got %0d want %0d", tag, k, sel_log[k], k + 1);
         end
      end
      checks++; if (gx_log[0] !== 8'd20 || gy_log[0] !== 7'd0) begin
         errors++; $display("FAIL %s origin0 got (%0d,%0d) want (20,0)", tag, gx_log[0], gy_log[0]);
      end
      checks++; if (gx_log[14] !== 8'd80 || gy_log[14] !== 7'd90) begin
         errors++; $display("FAIL %s origin14 got (%0d,%0d) want (80,90)", tag, gx_log[14], gy_log[14]);
      end
      checks++; if (done_after !== 1'b0 || busy_after !== 1'b0) begin
         errors++; $display("FAIL %s after_done got done=%b busy=%b want 0 0", tag, done_after, busy_after);
      end
   endtask

   task automatic test_cell_origin();
      load_blank();
      board[5] = 4'd10;
      run_frame(0);
      checks++; if (done_cyc != 175 || windows != 1 || plots != 141) begin
         errors++; $display("FAIL cell5_frame got done=%0d win=%0d plots=%0d want 175 1 141", done_cyc, windows, plots);
      end
      checks++; if (sel_log[0] !== 4'd10) begin
         errors++; $display("FAIL cell5_sel got %0d want 10", sel_log[0]);
      end
      checks++; if (gx_log[0] !== 8'd50 || gy_log[0] !== 7'd30) begin
         errors++; $display("FAIL cell5_origin got (%0d,%0d) want (50,30)", gx_log[0], gy_log[0]);
      end
      checks++; if (fvx_log[0] !== 8'd50 || fvy_log[0] !== 7'd30) begin
         errors++; $display("FAIL cell5_first_plot got (%0d,%0d) want (50,30)", fvx_log[0], fvy_log[0]);
      end
   endtask

   task automatic test_all_blank();
      load_blank();
      run_frame(0);
      checks++; if (done_cyc != 33) begin
         errors++; $display("FAIL blank_done got %0d want 33", done_cyc);
      end
      checks++; if (plots != 0 || en_total != 0) begin
         errors++; $display("FAIL blank_activity got plots=%0d en=%0d want 0 0", plots, en_total);
      end
   endtask

   // start presented during the DONE cycle must not launch a frame.
   task automatic test_back_to_back();
      logic seen;
      logic busy_seen;
      load_blank();
      seen = 1'b0; busy_seen = 1'b0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      checks++; if (seen !== 1'b1) begin
         errors++; $display("FAIL b2b_done got no done want done within 100");
      end
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (busy) busy_seen = 1'b1;
      end
      checks++; if (busy_seen !== 1'b0) begin
         errors++; $display("FAIL b2b_start_in_done got busy=1 want 0");
      end
      run_frame(0);
      checks++; if (done_cyc != 33) begin
         errors++; $display("FAIL b2b_restart got %0d want 33", done_cyc);
      end
   endtask

   task automatic test_reset_mid_draw();
      int   rises, in_cell3;
      logic prev;
      load_counting();
      rises = 0; in_cell3 = 0; prev = 1'b0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int n = 1; n <= 3000; n++) begin
         @(negedge clk);
         if (glyph_enable && !prev) rises++;
         prev = glyph_enable;
         if (rises == 4 && glyph_enable) in_cell3++;
         if (in_cell3 == 20) break;
      end
      checks++; if (in_cell3 != 20 || glyph_sel !== 4'd4 || vga_plot !== 1'b1) begin
         errors++; $display("FAIL rst_reach_cell3 got cyc=%0d sel=%0d plot=%b want 20 4 1", in_cell3, glyph_sel, vga_plot);
      end
      #2 reset = 1'b1;
      #1;
      checks++; if ({vga_plot, glyph_resetn, busy, glyph_enable} !== 4'b0000) begin
         errors++; $display("FAIL rst_async got plot/resetn/busy/en=%b want 0000", {vga_plot, glyph_resetn, busy, glyph_enable});
      end
      checks++; if ({glyph_sel, glyph_x, glyph_y, tile_addr} !== 23'd0) begin
         errors++; $display("FAIL rst_regs got sel=%0d x=%0d y=%0d addr=%0d want 0", glyph_sel, glyph_x, glyph_y, tile_addr);
      end
      @(negedge clk); reset = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (busy !== 1'b0 || vga_plot !== 1'b0) begin
         errors++; $display("FAIL rst_no_resume got busy=%b plot=%b want 0 0", busy, vga_plot);
      end
      run_frame(0);
      checks++; if (done_cyc != 2163 || sel_log[0] !== 4'd1 || plots != 2115) begin
         errors++; $display("FAIL rst_redraw got done=%0d sel0=%0d plots=%0d want 2163 1 2115", done_cyc, sel_log[0], plots);
      end
   endtask

   initial begin
      test_reset();
      test_full_board(0, "full");
      test_cell_origin();
      test_all_blank();
      test_full_board(500, "restart");
      test_back_to_back();
      test_reset_mid_draw();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
